// File: rtl/sram_rr_arbiter_pkg.sv
// rtl/sram_rr_arbiter_pkg.sv - shared ids, default widths and tag layout for the SRAM arbiter
package sram_rr_arbiter_pkg;

   // Requester ids; the id doubles as the bit index into the 2-bit vld/rdy/rsp vectors
   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // Default widths; data/address must track the attached SRAM
   localparam int DEF_BW_DATA = 64;
   localparam int DEF_BW_ADDR = 6;
   localparam int DEF_BW_CNT  = 16;

   // Bit positions of the fields inside a packed tag
   localparam int TAG_VLD_BIT = 2;
   localparam int TAG_ID_BIT  = 1;
   localparam int TAG_RD_BIT  = 0;

   // Tag that follows an accepted access down the return pipe
   typedef struct packed {
      logic vld;      // an access was accepted
      logic id;       // requester that issued it
      logic is_read;  // only reads produce a response
   } tag_t;

   localparam tag_t TAG_IDLE = '0;

   // One-hot response-valid vector for a requester id
   function automatic logic [1:0] id_onehot(input logic id);
      return (id == REQ1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// rtl/sram_rr_arbiter_if.sv - requester, response, SRAM-pin and counter bundle of the arbiter
interface sram_rr_arbiter_if #(
   parameter int BW_DATA = 64,
   parameter int BW_ADDR = 6,
   parameter int BW_CNT  = 16
) ();

   // Requester side
   logic [1:0]         req_vld;
   logic [1:0]         req_rdy;
   logic [1:0]         req_wen;
   logic [BW_ADDR-1:0] req_addr0;
   logic [BW_ADDR-1:0] req_addr1;
   logic [BW_DATA-1:0] req_data0;
   logic [BW_DATA-1:0] req_data1;

   // Read return
   logic [1:0]         rsp_vld;
   logic [BW_DATA-1:0] rsp_data;

   // SRAM pins
   logic               sram_cen;
   logic               sram_wen;
   logic               sram_oen;
   logic [BW_ADDR-1:0] sram_addr;
   logic [BW_DATA-1:0] sram_wdata;
   logic [BW_DATA-1:0] sram_rdata;

   // Grant statistics
   logic [BW_CNT-1:0]  gnt_cnt0;
   logic [BW_CNT-1:0]  gnt_cnt1;

   // Environment view: requesters plus the external SRAM
   modport master (
      output req_vld, req_wen, req_addr0, req_addr1, req_data0, req_data1, sram_rdata,
      input  req_rdy, rsp_vld, rsp_data, sram_cen, sram_wen, sram_oen, sram_addr,
             sram_wdata, gnt_cnt0, gnt_cnt1
   );

   // Arbiter view
   modport slave (
      input  req_vld, req_wen, req_addr0, req_addr1, req_data0, req_data1, sram_rdata,
      output req_rdy, rsp_vld, rsp_data, sram_cen, sram_wen, sram_oen, sram_addr,
             sram_wdata, gnt_cnt0, gnt_cnt1
   );

endinterface

// File: rtl/sram_rr_arbiter_gnt.sv
// rtl/sram_rr_arbiter_gnt.sv - two-way round-robin grant with last-granted memory
module sram_rr_arbiter_gnt
   import sram_rr_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] vld,
   input  logic       accept,
   output logic [1:0] rdy
);

   // Requester granted most recently; starts at REQ1 so REQ0 wins the first contention
   logic last_gnt;

   // Grant: a lone requester wins, contention goes to the one not granted last
   always_comb begin
      rdy = 2'b00;
      if (!rst) begin
         unique case (vld)
            2'b01:   rdy = 2'b01;
            2'b10:   rdy = 2'b10;
            2'b11:   rdy = (last_gnt == REQ0) ? 2'b10 : 2'b01;
            default: rdy = 2'b00;
         endcase
      end
   end

   // Remember the winner only when its request is actually taken
   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt <= REQ1;
      end else if (accept) begin
         last_gnt <= rdy[1];
      end
   end

endmodule

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - round-robin sharing of one single-port SRAM between two requesters
module sram_rr_arbiter
   import sram_rr_arbiter_pkg::*;
#(
   parameter int BW_DATA = DEF_BW_DATA,
   parameter int BW_ADDR = DEF_BW_ADDR,
   parameter int BW_CNT  = DEF_BW_CNT
) (
   input logic                i_clk,
   input logic                i_rst,
   sram_rr_arbiter_if.slave   bus
);

   localparam logic [BW_CNT-1:0] CNT_MAX = {BW_CNT{1'b1}};

   logic [1:0]         rdy;
   logic               accept;
   logic               win;
   logic               win_wen;
   logic [BW_ADDR-1:0] win_addr;
   logic [BW_DATA-1:0] win_data;

   logic               sram_cen_q;
   logic               sram_wen_q;
   logic               sram_oen_q;
   logic [BW_ADDR-1:0] sram_addr_q;
   logic [BW_DATA-1:0] sram_wdata_q;

   tag_t               tag_s1;
   tag_t               tag_s2;

   logic [1:0]         rsp_vld_q;
   logic [BW_DATA-1:0] rsp_data_q;

   logic [BW_CNT-1:0]  cnt0_q;
   logic [BW_CNT-1:0]  cnt1_q;

   sram_rr_arbiter_gnt u_gnt (
      .clk    (i_clk),
      .rst    (i_rst),
      .vld    (bus.req_vld),
      .accept (accept),
      .rdy    (rdy)
   );

   // rdy is one-hot or zero, so its upper bit is the winning id
   assign accept   = |(bus.req_vld & rdy);
   assign win      = rdy[1];
   assign win_wen  = bus.req_wen[win];
   assign win_addr = (win == REQ1) ? bus.req_addr1 : bus.req_addr0;
   assign win_data = (win == REQ1) ? bus.req_data1 : bus.req_data0;

   // Issue stage: the accepted access is presented to the SRAM for exactly one cycle
   always_ff @(posedge i_clk) begin
      if (i_rst || !accept) begin
         sram_cen_q   <= 1'b0;
         sram_wen_q   <= 1'b0;
         sram_oen_q   <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
      end else begin
         sram_cen_q   <= 1'b1;
         sram_wen_q   <= win_wen;
         sram_oen_q   <= ~win_wen;
         sram_addr_q  <= win_addr;
         sram_wdata_q <= win_data;
      end
   end

   // Tag pipe: stage 1 lines up with the issue cycle, stage 2 with SRAM read data
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tag_s1 <= TAG_IDLE;
         tag_s2 <= TAG_IDLE;
      end else begin
         tag_s1.vld     <= accept;
         tag_s1.id      <= win;
         tag_s1.is_read <= accept & ~win_wen;
         tag_s2         <= tag_s1;
      end
   end

   // Response register: capture SRAM data and pulse the owner's valid for reads only
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rsp_vld_q  <= 2'b00;
         rsp_data_q <= '0;
      end else if (tag_s2.vld && tag_s2.is_read) begin
         rsp_vld_q  <= id_onehot(tag_s2.id);
         rsp_data_q <= bus.sram_rdata;
      end else begin
         rsp_vld_q  <= 2'b00;
      end
   end

   // Saturating per-requester acceptance counters
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (accept) begin
         if (win == REQ0 && cnt0_q != CNT_MAX) cnt0_q <= cnt0_q + 1'b1;
         if (win == REQ1 && cnt1_q != CNT_MAX) cnt1_q <= cnt1_q + 1'b1;
      end
   end

   assign bus.req_rdy    = rdy;
   assign bus.sram_cen   = sram_cen_q;
   assign bus.sram_wen   = sram_wen_q;
   assign bus.sram_oen   = sram_oen_q;
   assign bus.sram_addr  = sram_addr_q;
   assign bus.sram_wdata = sram_wdata_q;
   assign bus.rsp_vld    = rsp_vld_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.gnt_cnt0   = cnt0_q;
   assign bus.gnt_cnt1   = cnt1_q;

endmodule
